// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared falling-edge register.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module reg_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic [IDXW-1:0]       owner
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [1:0]       state;
  logic [IDXW-1:0]  gnt_idx;
  logic [IDXW-1:0]  win_idx;
  logic             win_valid;
  logic [WIDTH-1:0] wr_data;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx   = IDXW'(i);
        win_valid = 1'b1;
      end
    end
  end
`else
  logic [IDXW-1:0] rr_ptr;
  int              cand;

  // Search upward from the pointer with wrap; the first set request wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it
    // unassigned and infer a latch.
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!win_valid && req[cand[IDXW-1:0]]) begin
        win_idx   = cand[IDXW-1:0];
        win_valid = 1'b1;
      end
    end
  end
`endif

  // Constant-index mux keeps the data select free of computed part-selects.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDXW'(i)) wr_data = data_in[i*WIDTH +: WIDTH];
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      grant   <= '0;
      ack     <= '0;
      q       <= '0;
      owner   <= '0;
      gnt_idx <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr  <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            grant   <= ONE << win_idx;
            gnt_idx <= win_idx;
            state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          grant <= '0;
          // A requester that withdrew before this edge gets no write and no ack.
          if (req[gnt_idx]) begin
            q     <= wr_data;
            ack   <= ONE << gnt_idx;
            owner <= gnt_idx;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr <= (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
            state <= S_ACK;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACK: begin
          ack   <= '0;
          state <= S_IDLE;
        end
        default: begin
          grant <= '0;
          ack   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a transfer-level model.
// Follows ARB_FIXED_PRIO_EN the same way the design does.
module tb_reg_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic [IDXW-1:0]       owner;

  reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant), .ack(ack), .q(q), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transfer-level model: phase 0 idle, 1 someone holds the grant, 2 write just acked.
  int m_phase, m_g, m_ptr, m_q, m_owner;
  int got_idx[$];
  int got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] one = 1;
    return one << i;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Winner = set request with the smallest priority distance from the pointer.
  function automatic int pick(input logic [NREQ-1:0] r);
    int best = -1;
    int bestd = NREQ;
    int d;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
`ifdef ARB_FIXED_PRIO_EN
        d = i;
`else
        d = (i - m_ptr + NREQ) % NREQ;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_g = 0; m_ptr = 0; m_q = 0; m_owner = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
    if (m_phase == 0) begin
      if (r != 0) begin
        m_g = pick(r);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (r[m_g]) begin
        m_q     = int'(d[m_g*WIDTH +: WIDTH]);
        m_owner = m_g;
        m_ptr   = (m_g + 1) % NREQ;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [NREQ-1:0] model_ack();
    return (m_phase == 2) ? onehot(m_g) : '0;
  endfunction

  task automatic compare_all();
    check("grant", 32'(grant), 32'((m_phase == 1) ? onehot(m_g) : '0));
    check("ack",   32'(ack),   32'(model_ack()));
    check("q",     32'(q),     32'(m_q));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy",  32'(busy),  32'(m_phase != 0));
  endtask

  // One falling edge of the design, then compare halfway to the next.
  task automatic tick();
    @(negedge clk);
    model_step(req, data_in);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Requesters hold 'want', drop during their ack cycle and re-raise afterwards.
  task automatic run_auto(input logic [NREQ-1:0] want, input int n);
    got_idx.delete();
    got_q.delete();
    for (int c = 0; c < 12 * n && got_idx.size() < n; c++) begin
      req = want & ~model_ack();
      tick();
      if (ack != '0) begin
        got_idx.push_back(idx_of(ack));
        got_q.push_back(int'(q));
      end
    end
    req = '0;
    tick();
  endtask

  task automatic check_seq(input string tag, input int n, input int eo[$], input int eq[$]);
    check({tag, "_count"}, 32'(got_idx.size()), 32'(n));
    for (int i = 0; i < got_idx.size() && i < n; i++) begin
      check({tag, "_idx"}, 32'(got_idx[i]), 32'(eo[i]));
      check({tag, "_q"},   32'(got_q[i]),   32'(eq[i]));
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] am;
    reset = 1'b1; req = '0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Single write by requester 2.
    data_in[2*WIDTH +: WIDTH] = 8'h3C;
    req = 4'b0100;
    tick(); check("sw_grant", 32'(grant), 32'h4);
    tick(); check("sw_q", 32'(q), 32'h3C); check("sw_ack", 32'(ack), 32'h4);
    check("sw_owner", 32'(owner), 32'd2);
    req = '0;
    tick(); check("sw_ack_clr", 32'(ack), 32'd0); check("sw_idle", 32'(busy), 32'd0);

    for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);

    // Wrap: pointer sits at 3 after requester 2 completed.
    run_auto(4'b1001, 2);
`ifdef ARB_FIXED_PRIO_EN
    check_seq("wrap", 2, '{0, 0}, '{8'h10, 8'h10});
`else
    check_seq("wrap", 2, '{3, 0}, '{8'h13, 8'h10});
`endif

    // Full rotation from a freshly reset pointer.
    pulse_reset();
    run_auto(4'b1111, 5);
`ifdef ARB_FIXED_PRIO_EN
    check_seq("rr", 5, '{0, 0, 0, 0, 0}, '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10});
`else
    check_seq("rr", 5, '{0, 1, 2, 3, 0}, '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10});
`endif

    // Withdrawal: grant lapses without a write and the pointer stays put.
    pulse_reset();
    req = 4'b0010;
    tick(); check("wd_grant", 32'(grant), 32'h2);
    req = '0;
    tick(); check("wd_nogrant", 32'(grant), 32'd0); check("wd_noack", 32'(ack), 32'd0);
    check("wd_q", 32'(q), 32'd0);
    req = 4'b0011;
    tick(); check("wd_regrant", 32'(grant), 32'h1);
    tick(); check("wd_ack", 32'(ack), 32'h1);
    req = '0;
    tick();

`ifdef ARB_FIXED_PRIO_EN
    // Requests held through ack: requester 0 wins every time.
    req = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      tick(); tick();
      check("fp_ack", 32'(ack), 32'h1);
      check("fp_q", 32'(q), 32'h10);
      tick();
    end
    req = '0;
    tick();
`endif

    // Reset mid-GRANT abandons the transfer.
    data_in[0 +: WIDTH] = 8'hA5;
    req = 4'b0001;
    tick(); check("mr_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    check("mr_q", 32'(q), 32'd0); check("mr_grant0", 32'(grant), 32'd0);
    check("mr_ack", 32'(ack), 32'd0); check("mr_busy", 32'(busy), 32'd0);
    req = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(); check("mr_nowrite", 32'(q), 32'd0);

    // Random traffic with withdrawals, changing data and occasional resets.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      am = model_ack();
      for (int i = 0; i < NREQ; i++) begin
        if (am[i]) r[i] = 1'b0;
        else if (!r[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
        else if (r[i] && $urandom_range(0, 15) == 0) r[i] = 1'b0;
        data_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      req = r;
      if ($urandom_range(0, 499) == 0) pulse_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter sharing one WIDTH-bit storage register (bank of falling-edge D flip-flops with async reset) among NREQ requesters.
- Each requester raises req with its write data; the arbiter grants one requester at a time, writes its data into the shared register and returns a one-cycle ack.
- Sits between multiple producer blocks and the shared state register in the module-3 datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data/register width in bits.
- IDXW, 2, width of owner index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- req  input  NREQ  request per requester; level, held until ack.
- data_in  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot grant, registered.
- ack  output  NREQ  one-hot, one-cycle write-complete pulse.
- q  output  WIDTH  shared register contents.
- busy  output  1  high in GRANT or ACK state.
- owner  output  IDXW  index of last requester whose write completed.

Behaviour:
- Reset (async, reset=1): state=IDLE, grant=0, ack=0, q=0, owner=0, rr pointer=0, busy=0. Held while reset=1.
- States: IDLE, GRANT, ACK. busy = (state != IDLE), combinational from state.
- IDLE: on falling edge with req != 0, select winner = first set req bit searching from rr pointer upward with wrap (NREQ-1 -> 0). Then grant<=onehot(winner), state<=GRANT. If req == 0, stay IDLE, outputs unchanged.
- GRANT, req[g]=1 on falling edge: q<=data_in[g], ack<=onehot(g), grant<=0, owner<=g, rr pointer<=(g+1) mod NREQ, state<=ACK.
- GRANT, req[g]=0 (withdrawn): no write; grant<=0, ack stays 0, pointer unchanged, state<=IDLE.
- ACK: on next falling edge ack<=0, state<=IDLE. Requests are not sampled in ACK. Requester g must drop req during its ack cycle; if it does not, it is treated as a new request in IDLE.
- Latency: req sampled at edge N -> grant at N, write and ack at N+1, ack clears at N+2. Minimum 3 edges per transfer; at most one write per 3 edges.
- Fairness: after requester i completes, it has lowest priority. With all req high, grants rotate 0,1,2,3,0,...
- Only the granted requester's data is written. data_in of other requesters is ignored. Data is sampled at the GRANT edge, not the IDLE edge.
- Reset asserted mid-transfer (GRANT or ACK): transfer abandoned. q returns to 0, ack/grant cleared, no partial write.
- grant and ack are never non-zero in the same cycle. Each is always zero or one-hot.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority; winner is the lowest-indexed set req bit. The rr pointer is not implemented and its update is removed. All other timing is identical.
- Undefined: round-robin as specified above.

Test Plan:
- Reset check: reset=1 mid-GRANT with data_in[0]=8'hA5 -> q=8'h00, grant=0, ack=0, busy=0 immediately; no write after reset release.
- Single write: req=4'b0100, data_in[2]=8'h3C -> grant=4'b0100 at edge 1, q=8'h3C and ack=4'b0100 at edge 2, owner=2, ack=0 and busy=0 at edge 3.
- Round-robin: req=4'b1111 held, requesters drop req on ack and re-raise next cycle, data_in[i]=8'h10+i -> ack order 0,1,2,3,0; q sequence 8'h10,8'h11,8'h12,8'h13,8'h10.
- Wrap: pointer=3 after owner=2, req=4'b1001 -> requester 3 granted first, then 0.
- Withdrawal: req=4'b0010 granted, req dropped before GRANT edge -> no ack, q unchanged, pointer unchanged, next req=4'b0011 grants requester 0 if pointer=0.
- ARB_FIXED_PRIO_EN defined: req=4'b1111 held continuously -> requester 0 wins every transfer; ack=4'b0001 repeated, q always equals data_in[0].
